operand_capture_queue: RTL and testbench
========================================

OPERAND_CAPTURE_QUEUE -- requirements
Module: operand_capture_queue

Interface
REQ-001 Parameter XLEN, default 32, operand/data width.
REQ-002 Parameter DEPTH, default 4, entry count; power of two, >=2.
REQ-003 Parameter NFWD, default 2, number of forwarding (writeback) ports.
REQ-004 Parameter CTRL_W, default 14, width of opaque control bundle carried per entry.
REQ-005 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-006 Port rst_n  in  1  reset, synchronous, active-low.
REQ-007 Port flush  in  1  synchronous clear of all entries (mispredict/exception).
REQ-008 Ports in_valid in 1, in_ready out 1  enqueue handshake.
REQ-009 Ports in_fp in 1, in_rd in 5, in_ctrl in CTRL_W  register-file select, destination, control bundle.
REQ-010 Ports in_rs1/in_rs2 in 5, in_s1/in_s2 in XLEN, in_s1_valid/in_s2_valid in 1  source address, value, value-valid.
REQ-011 Ports fwd_valid in NFWD, fwd_fp in NFWD, fwd_addr in 5*NFWD, fwd_data in XLEN*NFWD  forwarding ports, port k in slice k.
REQ-012 Ports out_valid out 1, out_ready in 1  dequeue handshake.
REQ-013 Ports out_fp 1, out_rd 5, out_ctrl CTRL_W, out_s1 XLEN, out_s2 XLEN  head-entry fields, all outputs.
REQ-014 Ports count out clog2(DEPTH)+1, full out 1, empty out 1  occupancy.

Function
REQ-015 Storage SHALL be a circular buffer: head/tail pointers wrap modulo DEPTH; in-order dequeue only.
REQ-016 Entry fields: fp, rd, ctrl, rs1, rs2, s1, s2, v1, v2, occupied.
REQ-017 in_ready SHALL equal !full, independent of out_ready (no same-cycle pass-through when full).
REQ-018 Enqueue occurs when in_valid & in_ready; entry written at tail, tail advances.
REQ-019 Operand n (1,2) at enqueue: v=1 if in_sn_valid, or if in_fp==0 & in_rsn==0 (value forced to 0); else v=0, value 0.
REQ-020 Integer source x0 SHALL never match a forwarding port; fp register f0 SHALL match normally.
REQ-021 Forwarding match for pending operand: fwd_valid[k] & fwd_addr[k]==rsn & fwd_fp[k]==entry fp; on match, value<=fwd_data[k], v<=1 at the edge.
REQ-022 Multiple matching ports in one cycle: lowest index k wins.
REQ-023 Snooping applies to every occupied pending operand each cycle and to the enqueuing instruction in its enqueue cycle.
REQ-024 Already-valid operands SHALL never be overwritten by forwarding.
REQ-025 out_valid = head occupied & head v1 & head v2; out fields combinational from head entry registers.
REQ-026 Latency: enqueue with both operands valid in cycle N -> out_valid in N+1; forwarding capture in cycle N -> visible at head in N+1.
REQ-027 Dequeue when out_valid & out_ready; head cleared, head advances.
REQ-028 Head not ready SHALL block younger ready entries (no bypass).
REQ-029 Simultaneous enqueue and dequeue SHALL leave count unchanged; allowed when not full, including count 1.
REQ-030 count SHALL track occupancy 0..DEPTH; full = count==DEPTH, empty = count==0.
REQ-031 flush SHALL clear all occupied bits, pointers, count in the next edge; same-cycle enqueue/dequeue ignored; flush overrides everything except reset.
REQ-032 Enqueue with in_valid while full SHALL be dropped by source protocol; queue state unchanged.

Reset
REQ-033 rst_n low at an edge: head=tail=0, count=0, all occupied/v bits 0, entry data 0.
REQ-034 During/after reset: out_valid=0, out fields 0, empty=1, full=0, in_ready=1.
REQ-035 Reset mid-operation SHALL discard all entries, including pending forwarding captures that cycle.

Verification
REQ-036 Enqueue rd=3, s1=0x11 v, s2=0x22 v, out_ready=1 -> next cycle out_valid=1, out_s1=0x11, out_s2=0x22; then empty=1.
REQ-037 Enqueue rs1=5 not valid; 2 cycles later fwd_valid[1]=1, addr=5, fp=0, data=0xABCD -> out_valid next cycle, out_s1=0xABCD.
REQ-038 Same-cycle enqueue rs2=7 invalid and fwd ports 0,1 both addr 7 (data 0x1, 0x2) -> captured out_s2=0x1.
REQ-039 Integer rs1=0 invalid with fwd addr 0 data 0xFFFF -> out_s1=0; fp rs1=0 pending with fp fwd addr 0 data 0x3F80_0000 -> captured.
REQ-040 Fill DEPTH=4 with head pending, out_ready=1 -> full=1, in_ready=0, out_valid=0; forward head operand -> drains 4 in order over 4 cycles, pointers wrap.
REQ-041 Queue count 3, assert flush with in_valid=1 -> next cycle count=0, empty=1, out_valid=0; rst_n low mid-fill -> same.

Source files
------------

// File: rtl/operand_capture_queue.sv
// In-order operand capture queue: holds issued instructions until both source
// operands are valid, snooping writeback forwarding ports for pending operands.
module operand_capture_queue #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned NFWD   = 2,
  parameter int unsigned CTRL_W = 14
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_fp,
  input  logic [4:0]                 in_rd,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [XLEN-1:0]            in_s1,
  input  logic [XLEN-1:0]            in_s2,
  input  logic                       in_s1_valid,
  input  logic                       in_s2_valid,
  input  logic [NFWD-1:0]            fwd_valid,
  input  logic [NFWD-1:0]            fwd_fp,
  input  logic [5*NFWD-1:0]          fwd_addr,
  input  logic [XLEN*NFWD-1:0]       fwd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_fp,
  output logic [4:0]                 out_rd,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [XLEN-1:0]            out_s1,
  output logic [XLEN-1:0]            out_s2,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic              r_fp   [DEPTH];
  logic [4:0]        r_rd   [DEPTH];
  logic [CTRL_W-1:0] r_ctrl [DEPTH];
  logic [4:0]        r_rs1  [DEPTH];
  logic [4:0]        r_rs2  [DEPTH];
  logic [XLEN-1:0]   r_s1   [DEPTH];
  logic [XLEN-1:0]   r_s2   [DEPTH];
  logic              r_v1   [DEPTH];
  logic              r_v2   [DEPTH];
  logic              r_occ  [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [XLEN:0]     w_snp1 [DEPTH];
  logic [XLEN:0]     w_snp2 [DEPTH];
  logic [XLEN:0]     w_in_op1;
  logic [XLEN:0]     w_in_op2;
  logic              w_full;
  logic              w_enq;
  logic              w_deq;

  // Returns {hit, data}; lowest-index port wins, integer x0 never matches.
  function automatic logic [XLEN:0] snoop(input logic fp, input logic [4:0] addr);
    logic            hit;
    logic [XLEN-1:0] data;
    hit  = 1'b0;
    data = '0;
    for (int unsigned k = 0; k < NFWD; k++) begin
      if (!hit && fwd_valid[k] && (fwd_fp[k] == fp) &&
          (fwd_addr[5*k +: 5] == addr) && (fp || (addr != 5'd0))) begin
        hit  = 1'b1;
        data = fwd_data[XLEN*k +: XLEN];
      end
    end
    return {hit, data};
  endfunction

  // Integer x0 reads as zero regardless of the supplied value.
  function automatic logic [XLEN:0] enq_operand(input logic fp, input logic [4:0] rs,
                                                input logic [XLEN-1:0] s, input logic sv);
    logic [XLEN:0] w_hit;
    w_hit = snoop(fp, rs);
    if (!fp && (rs == 5'd0)) return {1'b1, {XLEN{1'b0}}};
    else if (sv)             return {1'b1, s};
    else if (w_hit[XLEN])    return w_hit;
    else                     return '0;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_snp1[i] = snoop(r_fp[i], r_rs1[i]);
      w_snp2[i] = snoop(r_fp[i], r_rs2[i]);
    end
    w_in_op1 = enq_operand(in_fp, in_rs1, in_s1, in_s1_valid);
    w_in_op2 = enq_operand(in_fp, in_rs2, in_s2, in_s2_valid);
  end

  assign w_full    = (r_count == CW'(DEPTH));
  assign full      = w_full;
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign in_ready  = !w_full;
  assign out_valid = r_occ[r_head] & r_v1[r_head] & r_v2[r_head];
  assign out_fp    = r_fp[r_head];
  assign out_rd    = r_rd[r_head];
  assign out_ctrl  = r_ctrl[r_head];
  assign out_s1    = r_s1[r_head];
  assign out_s2    = r_s2[r_head];
  assign w_enq     = in_valid & !w_full;
  assign w_deq     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_fp[i]   <= 1'b0;
        r_rd[i]   <= '0;
        r_ctrl[i] <= '0;
        r_rs1[i]  <= '0;
        r_rs2[i]  <= '0;
        r_s1[i]   <= '0;
        r_s2[i]   <= '0;
        r_v1[i]   <= 1'b0;
        r_v2[i]   <= 1'b0;
        r_occ[i]  <= 1'b0;
      end
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_v1[i]  <= 1'b0;
        r_v2[i]  <= 1'b0;
        r_occ[i] <= 1'b0;
      end
    end else begin
      // Snoop never touches the dequeuing head (both valid) or the enqueue slot (unoccupied).
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (r_occ[i] && !r_v1[i] && w_snp1[i][XLEN]) begin
          r_s1[i] <= w_snp1[i][XLEN-1:0];
          r_v1[i] <= 1'b1;
        end
        if (r_occ[i] && !r_v2[i] && w_snp2[i][XLEN]) begin
          r_s2[i] <= w_snp2[i][XLEN-1:0];
          r_v2[i] <= 1'b1;
        end
      end
      if (w_deq) begin
        r_occ[r_head] <= 1'b0;
        r_v1[r_head]  <= 1'b0;
        r_v2[r_head]  <= 1'b0;
        r_head        <= r_head + PW'(1);
      end
      if (w_enq) begin
        r_fp[r_tail]   <= in_fp;
        r_rd[r_tail]   <= in_rd;
        r_ctrl[r_tail] <= in_ctrl;
        r_rs1[r_tail]  <= in_rs1;
        r_rs2[r_tail]  <= in_rs2;
        r_s1[r_tail]   <= w_in_op1[XLEN-1:0];
        r_s2[r_tail]   <= w_in_op2[XLEN-1:0];
        r_v1[r_tail]   <= w_in_op1[XLEN];
        r_v2[r_tail]   <= w_in_op2[XLEN];
        r_occ[r_tail]  <= 1'b1;
        r_tail         <= r_tail + PW'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_capture_queue.sv
// Scoreboard bench for operand_capture_queue: directed enqueues push expected
// head contents; a negedge monitor pops and compares on every dequeue.
module tb_operand_capture_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, in_fp;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [13:0] in_ctrl;
  logic [31:0] in_s1, in_s2;
  logic        in_s1_valid, in_s2_valid;
  logic [1:0]  fwd_valid, fwd_fp;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic        out_valid, out_ready, out_fp;
  logic [4:0]  out_rd;
  logic [13:0] out_ctrl;
  logic [31:0] out_s1, out_s2;
  logic [2:0]  count;
  logic        full, empty;

  typedef struct {
    logic        fp;
    logic [4:0]  rd;
    logic [13:0] ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   nchecks = 0;
  int   nerr    = 0;
  bit   started = 1'b0;

  operand_capture_queue #(.XLEN(32), .DEPTH(4), .NFWD(2), .CTRL_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fp(in_fp), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_s1(in_s1), .in_s2(in_s2),
    .in_s1_valid(in_s1_valid), .in_s2_valid(in_s2_valid),
    .fwd_valid(fwd_valid), .fwd_fp(fwd_fp), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_fp(out_fp), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .out_s1(out_s1), .out_s2(out_s2),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int k, input logic fp, input logic [4:0] addr,
                         input logic [31:0] data);
    fwd_valid[k]         = 1'b1;
    fwd_fp[k]            = fp;
    fwd_addr[5*k +: 5]   = addr;
    fwd_data[32*k +: 32] = data;
  endtask

  task automatic clr_fwd();
    fwd_valid = '0;
    fwd_fp    = '0;
    fwd_addr  = '0;
    fwd_data  = '0;
  endtask

  // Enqueue one instruction; when push is set, the expected head contents go to the scoreboard.
  task automatic enq(input logic fp, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] s1, input logic v1,
                     input logic [31:0] s2, input logic v2, input bit push,
                     input logic [31:0] e1, input logic [31:0] e2);
    exp_t x;
    chk("in_ready_before_enq", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_fp = fp; in_rd = rd; in_ctrl = 14'h1000 | {9'd0, rd};
    in_rs1 = rs1; in_rs2 = rs2; in_s1 = s1; in_s2 = s2;
    in_s1_valid = v1; in_s2_valid = v2;
    if (push) begin
      x.fp = fp; x.rd = rd; x.ctrl = 14'h1000 | {9'd0, rd}; x.s1 = e1; x.s2 = e2;
      sb.push_back(x);
    end
    step();
    in_valid = 1'b0; in_s1_valid = 1'b0; in_s2_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (started && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_output: got rd %0d expected no output", out_rd);
      end else begin
        e = sb.pop_front();
        chk("out_rd",   {59'd0, out_rd},   {59'd0, e.rd});
        chk("out_fp",   {63'd0, out_fp},   {63'd0, e.fp});
        chk("out_ctrl", {50'd0, out_ctrl}, {50'd0, e.ctrl});
        chk("out_s1",   {32'd0, out_s1},   {32'd0, e.s1});
        chk("out_s2",   {32'd0, out_s2},   {32'd0, e.s2});
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_fp = 1'b0; in_rd = '0; in_ctrl = '0;
    in_rs1 = '0; in_rs2 = '0; in_s1 = '0; in_s2 = '0; in_s1_valid = 1'b0; in_s2_valid = 1'b0;
    out_ready = 1'b0;
    clr_fwd();
    step();
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_empty",     {63'd0, empty},     64'd1);
    chk("rst_full",      {63'd0, full},      64'd0);
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_count",     {61'd0, count},     64'd0);
    chk("rst_out_s1",    {32'd0, out_s1},    64'd0);
    chk("rst_out_rd",    {59'd0, out_rd},    64'd0);
    step();
    rst_n = 1'b1;
    started = 1'b1;

    // Both operands valid: visible the next cycle, then drained.
    out_ready = 1'b1;
    enq(1'b0, 5'd3, 5'd1, 5'd2, 32'h11, 1'b1, 32'h22, 1'b1, 1'b1, 32'h11, 32'h22);
    chk("lat_valid_next", {63'd0, out_valid}, 64'd1);
    step();
    chk("drain_empty", {63'd0, empty}, 64'd1);
    chk("drain_count", {61'd0, count}, 64'd0);

    // rs1 pending, captured from port 1 two cycles later.
    enq(1'b0, 5'd4, 5'd5, 5'd6, 32'h0, 1'b0, 32'h33, 1'b1, 1'b1, 32'hABCD, 32'h33);
    chk("pending_no_valid", {63'd0, out_valid}, 64'd0);
    step();
    set_fwd(0, 1'b0, 5'd6, 32'hDEAD);
    set_fwd(1, 1'b0, 5'd5, 32'hABCD);
    step();
    clr_fwd();
    chk("fwd_capture_valid", {63'd0, out_valid}, 64'd1);
    step();

    // Same-cycle capture at enqueue, both ports match: port 0 wins.
    set_fwd(0, 1'b0, 5'd7, 32'h1);
    set_fwd(1, 1'b0, 5'd7, 32'h2);
    enq(1'b0, 5'd5, 5'd8, 5'd7, 32'h44, 1'b1, 32'h0, 1'b0, 1'b1, 32'h44, 32'h1);
    clr_fwd();
    chk("enq_snoop_valid", {63'd0, out_valid}, 64'd1);
    step();

    // A valid operand is not overwritten by a matching forward.
    out_ready = 1'b0;
    enq(1'b0, 5'd6, 5'd9, 5'd10, 32'h55, 1'b1, 32'h0, 1'b0, 1'b1, 32'h55, 32'hAA);
    set_fwd(0, 1'b0, 5'd9, 32'h99);
    set_fwd(1, 1'b0, 5'd10, 32'hAA);
    step();
    clr_fwd();
    out_ready = 1'b1;
    step();

    // Integer x0 reads zero and ignores forwarding; fp f0 is captured normally.
    set_fwd(0, 1'b0, 5'd0, 32'hFFFF);
    enq(1'b0, 5'd7, 5'd0, 5'd1, 32'h0, 1'b0, 32'h66, 1'b1, 1'b1, 32'h0, 32'h66);
    clr_fwd();
    step();
    out_ready = 1'b0;
    enq(1'b1, 5'd8, 5'd0, 5'd1, 32'h0, 1'b0, 32'h77, 1'b1, 1'b1, 32'h3F80_0000, 32'h77);
    chk("fp_f0_pending", {63'd0, out_valid}, 64'd0);
    set_fwd(0, 1'b0, 5'd0, 32'h1234);
    step();
    chk("fp_f0_int_fwd_ignored", {63'd0, out_valid}, 64'd0);
    clr_fwd();
    set_fwd(1, 1'b1, 5'd0, 32'h3F80_0000);
    step();
    clr_fwd();
    chk("fp_f0_captured", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    step();

    // Fill with pending head: younger ready entries are blocked, then drain in order with wrap.
    enq(1'b0, 5'd10, 5'd12, 5'd1, 32'h0, 1'b0, 32'hA0, 1'b1, 1'b1, 32'hC0DE, 32'hA0);
    enq(1'b0, 5'd11, 5'd1, 5'd2, 32'hB1, 1'b1, 32'hB2, 1'b1, 1'b1, 32'hB1, 32'hB2);
    enq(1'b0, 5'd12, 5'd1, 5'd2, 32'hC1, 1'b1, 32'hC2, 1'b1, 1'b1, 32'hC1, 32'hC2);
    enq(1'b0, 5'd13, 5'd1, 5'd2, 32'hD1, 1'b1, 32'hD2, 1'b1, 1'b1, 32'hD1, 32'hD2);
    chk("fill_full",      {63'd0, full},      64'd1);
    chk("fill_in_ready",  {63'd0, in_ready},  64'd0);
    chk("fill_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fill_count",     {61'd0, count},     64'd4);
    in_valid = 1'b1; in_rd = 5'd31; in_s1_valid = 1'b1; in_s2_valid = 1'b1;
    step();
    in_valid = 1'b0; in_s1_valid = 1'b0; in_s2_valid = 1'b0;
    chk("full_enq_dropped", {61'd0, count}, 64'd4);
    set_fwd(0, 1'b0, 5'd12, 32'hC0DE);
    step();
    clr_fwd();
    chk("head_released", {63'd0, out_valid}, 64'd1);
    chk("head_rel_count", {61'd0, count}, 64'd4);
    for (int i = 3; i >= 0; i--) begin
      step();
      chk("drain_seq_count", {61'd0, count}, 64'(i));
    end

    // Simultaneous enqueue and dequeue at count 1.
    enq(1'b0, 5'd14, 5'd1, 5'd2, 32'hE1, 1'b1, 32'hE2, 1'b1, 1'b1, 32'hE1, 32'hE2);
    enq(1'b0, 5'd15, 5'd1, 5'd2, 32'hF1, 1'b1, 32'hF2, 1'b1, 1'b1, 32'hF1, 32'hF2);
    chk("enq_deq_count", {61'd0, count}, 64'd1);
    step();
    chk("enq_deq_drained", {61'd0, count}, 64'd0);

    // Flush at count 3 with a simultaneous enqueue attempt.
    out_ready = 1'b0;
    enq(1'b0, 5'd16, 5'd1, 5'd2, 32'h1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    enq(1'b0, 5'd17, 5'd1, 5'd2, 32'h1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    enq(1'b0, 5'd18, 5'd1, 5'd2, 32'h1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("pre_flush_count", {61'd0, count}, 64'd3);
    flush = 1'b1; in_valid = 1'b1; in_s1_valid = 1'b1; in_s2_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; in_s1_valid = 1'b0; in_s2_valid = 1'b0;
    chk("flush_count",     {61'd0, count},     64'd0);
    chk("flush_empty",     {63'd0, empty},     64'd1);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_in_ready",  {63'd0, in_ready},  64'd1);
    step();
    chk("flush_enq_ignored", {61'd0, count}, 64'd0);

    // Reset mid-fill discards entries and a same-cycle capture.
    enq(1'b0, 5'd19, 5'd1, 5'd2, 32'h1, 1'b1, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    enq(1'b0, 5'd20, 5'd20, 5'd2, 32'h0, 1'b0, 32'h2, 1'b1, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    set_fwd(0, 1'b0, 5'd20, 32'h5555);
    step();
    chk("mid_rst_count",     {61'd0, count},     64'd0);
    chk("mid_rst_empty",     {63'd0, empty},     64'd1);
    chk("mid_rst_full",      {63'd0, full},      64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_out_s1",    {32'd0, out_s1},    64'd0);
    rst_n = 1'b1;
    clr_fwd();
    step();
    chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

    // Normal operation resumes after reset.
    out_ready = 1'b1;
    enq(1'b0, 5'd21, 5'd3, 5'd4, 32'h2121, 1'b1, 32'h4242, 1'b1, 1'b1, 32'h2121, 32'h4242);
    step();
    step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    chk("final_empty", {63'd0, empty}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
